clock_time_counter: RTL

- Time-keeping core of the real-time clock: keeps hours, minutes and seconds as binary counters, stepped by an internal 1 Hz prescaler.
- Sits directly upstream of the three bin_to_bcd converters. Each 6-bit output feeds one converter unchanged.
- Includes a small set-mode state machine so the user can adjust hours and minutes with two debounced, single-cycle button pulses.

---
 rtl/clock_pkg.sv | 20 ++
 rtl/tick_gen.sv | 44 ++++
 rtl/clock_time_counter.sv | 104 ++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the real-time clock time-keeping core.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  localparam int unsigned TIME_W   = 6;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v == max) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// 1 Hz prescaler (active while en) and edit blink divider (active while !en).
module tick_gen #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BLINK_DIV = CLK_FREQ / 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick,
  output logic blink
);

  localparam int unsigned PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);

  logic [PW-1:0] presc_q;
  logic [BW-1:0] bcnt_q;
  logic          blink_q;

  // High during the last cycle of each second; the wrap happens on the next edge.
  assign tick  = en && (presc_q == PW'(CLK_FREQ - 1));
  assign blink = blink_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      bcnt_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      presc_q <= '0;
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_q  <= '0;
        blink_q <= ~blink_q;
      end else begin
        bcnt_q <= bcnt_q + BW'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// Hours/minutes/seconds counters with a RUN -> SET_HOUR -> SET_MIN edit state machine.
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BLINK_DIV = CLK_FREQ / 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_btn,
  input  logic              inc_btn,
  output logic [TIME_W-1:0] seconds,
  output logic [TIME_W-1:0] minutes,
  output logic [TIME_W-1:0] hours,
  output logic              sec_pulse,
  output logic              edit_hours,
  output logic              edit_minutes,
  output logic              blink
);

  localparam logic [TIME_W-1:0] SecM  = TIME_W'(SEC_MAX);
  localparam logic [TIME_W-1:0] MinM  = TIME_W'(MIN_MAX);
  localparam logic [TIME_W-1:0] HourM = TIME_W'(HOUR_MAX);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic              sec_pulse_q, edit_hours_q, edit_minutes_q;
  logic              tick, tick_rst;

  // Every state change restarts both dividers: blink phase begins at 0 on entry, and
  // leaving SET_MIN starts a full second.
  assign tick_rst = rst | mode_btn;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BLINK_DIV(BLINK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (tick_rst),
    .en   (state_q == RUN),
    .tick (tick),
    .blink(blink)
  );

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    unique case (state_q)
      RUN: begin
        if (tick) begin
          sec_d = wrap_inc(sec_q, SecM);
          if (sec_q == SecM) begin
            min_d = wrap_inc(min_q, MinM);
            if (min_q == MinM) hour_d = wrap_inc(hour_q, HourM);
          end
        end
        if (mode_btn) state_d = SET_HOUR;
      end
      SET_HOUR: begin
        if (mode_btn)     state_d = SET_MIN;
        else if (inc_btn) hour_d  = wrap_inc(hour_q, HourM);
      end
      SET_MIN: begin
        if (mode_btn) begin
          state_d = RUN;
          sec_d   = '0;
        end else if (inc_btn) begin
          min_d = wrap_inc(min_q, MinM);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      sec_q          <= '0;
      min_q          <= '0;
      hour_q         <= '0;
      sec_pulse_q    <= 1'b0;
      edit_hours_q   <= 1'b0;
      edit_minutes_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sec_q          <= sec_d;
      min_q          <= min_d;
      hour_q         <= hour_d;
      sec_pulse_q    <= tick;
      edit_hours_q   <= (state_d == SET_HOUR);
      edit_minutes_q <= (state_d == SET_MIN);
    end
  end

  assign seconds      = sec_q;
  assign minutes      = min_q;
  assign hours        = hour_q;
  assign sec_pulse    = sec_pulse_q;
  assign edit_hours   = edit_hours_q;
  assign edit_minutes = edit_minutes_q;

endmodule
